// File: rtl/uart_tx_parity.sv
// rtl/uart_tx_parity.sv - UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN for 8E1 framing; leave it undefined for 8N1.
module uart_tx_parity #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    bit_end   = (cnt_q == CNT_LAST);

    // The bit timer only runs inside a frame and always wraps to 0 at a bit end.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_wr && tx_en) begin
          state_d  = S_START;
          cnt_d    = '0;
          shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops, glitch-free.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// tb/tb_uart_tx_parity.sv - randomized and directed frame checks for uart_tx_parity.
module tb_uart_tx_parity;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       txd;

  int checks = 0;
  int errors = 0;

  uart_tx_parity #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_wr(tx_wr),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line levels for one frame, one entry per serial bit.
  function automatic int frame_bits(input logic [7:0] d, output logic bits [12]);
    int n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[n++] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[n++] = ($countones(d) % 2) == 1;
`endif
    bits[n++] = 1'b1;
    return n;
  endfunction

  // Entered at a sample point of an idle cycle; leaves at the idle cycle after the frame.
  // mode 0: quiet, 1: random input noise mid-frame, 2: repeated tx_wr of 8'hFF mid-frame.
  task automatic send(input logic [7:0] d, input int mode);
    logic bits [12];
    int nb, total;
    nb = frame_bits(d, bits);
    total = nb * CPB;
    tx_data = d; tx_wr = 1'b1; tx_en = 1'b1;
    step();
    tx_wr = 1'b0;
    for (int k = 0; k < total; k++) begin
      check($sformatf("txd d=%02h cyc=%0d", d, k + 1), txd, bits[k / CPB]);
      check($sformatf("busy d=%02h cyc=%0d", d, k + 1), tx_busy, 1'b1);
      check($sformatf("done d=%02h cyc=%0d", d, k + 1), tx_done, (k == total - 1));
      if (mode == 1) begin
        tx_data = 8'($urandom); tx_wr = 1'($urandom); tx_en = 1'($urandom);
      end else if (mode == 2) begin
        tx_data = 8'hFF; tx_wr = 1'b1; tx_en = 1'b1;
      end
      step();
    end
    tx_wr = 1'b0; tx_en = 1'b1;
    check($sformatf("idle_txd d=%02h", d), txd, 1'b1);
    check($sformatf("idle_busy d=%02h", d), tx_busy, 1'b0);
    check($sformatf("idle_done d=%02h", d), tx_done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tx_en = 1'b0; tx_wr = 1'b0; tx_data = 8'h00;
    #1;
    check("reset_txd", txd, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    step();
    reset = 1'b0;
    step();

    send(8'hA5, 0);
    send(8'h07, 0);
    send(8'h00, 0);

    // Requests with the enable low must not start a frame.
    tx_en = 1'b0; tx_wr = 1'b1; tx_data = 8'h3C;
    for (int k = 0; k < 2 * CPB; k++) begin
      step();
      check($sformatf("dis_txd cyc=%0d", k), txd, 1'b1);
      check($sformatf("dis_busy cyc=%0d", k), tx_busy, 1'b0);
    end
    tx_wr = 1'b0; tx_en = 1'b1;

    send(8'h5A, 2);
    // Back-to-back: each send starts on the single idle cycle after the previous frame.
    send(8'hC3, 0);
    send(8'h81, 0);

    for (int r = 0; r < 6; r++) send(8'($urandom), 1);

    // Abort in the middle of data bit 3 (bit slot 4).
    tx_data = 8'hF0; tx_wr = 1'b1; tx_en = 1'b1;
    step();
    tx_wr = 1'b0;
    repeat (4 * CPB + 1) step();
    check("pre_abort_txd", txd, 1'b0);
    reset = 1'b1;
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_done", tx_done, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 8 * CPB; k++) begin
      step();
      check($sformatf("post_abort_done cyc=%0d", k), tx_done, 1'b0);
      check($sformatf("post_abort_txd cyc=%0d", k), txd, 1'b1);
    end
    send(8'h96, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
